// File: rtl/serial_subtractor_pkg.sv
// Shared FSM state encoding and default width for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = x - y - bi, bo set when a borrow is required.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin, LSB first) with valid/ready on both sides.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned    CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic [WIDTH-1:0] a_nx;
  logic [WIDTH-1:0] b_nx;
  logic [WIDTH-1:0] d_nx;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             bit_d;
  logic             bit_bo;
  logic             accept;
  logic             last;

  full_subtractor_bit u_bit (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (br),
    .d  (bit_d),
    .bo (bit_bo)
  );

  assign accept = in_valid && in_ready;
  assign last   = (cnt == LAST);

  // Shift via >> and a bit insert so WIDTH=1 needs no zero-width slice.
  always_comb begin
    a_nx = a_sr >> 1;
    b_nx = b_sr >> 1;
    d_nx = d_sr >> 1;
    d_nx[WIDTH-1] = bit_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept)               state_next = ST_SHIFT;
      ST_SHIFT: if (last)                 state_next = ST_DONE;
      ST_DONE:  if (out_valid && out_ready) state_next = ST_IDLE;
      default:                            state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (state == ST_IDLE) begin
      if (accept) begin
        a_sr <= a;
        b_sr <= b;
        br   <= bin;
        d_sr <= '0;
        cnt  <= '0;
      end
    end else if (state == ST_SHIFT) begin
      a_sr <= a_nx;
      b_sr <= b_nx;
      d_sr <= d_nx;
      br   <= bit_bo;
      cnt  <= cnt + CW'(1);
    end
  end

  assign diff = d_sr;
  assign bout = br;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;

  // Final diff MSB is the bit produced on the last shift edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      ovf   <= 1'b0;
    end else if (state == ST_SHIFT && last) begin
      ovf   <= (a_msb ^ b_msb) & (a_msb ^ bit_d);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed scoreboard bench for serial_subtractor at the default 4-bit width.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a_i;
  logic [3:0] b_i;
  logic       bin_i;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] diff;
  logic       bout;
  logic       out_valid;
  logic       out_ready;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] diff;
    logic       bout;
    logic       ovf;
  } res_t;

  res_t sb[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a_i),
    .b         (b_i),
    .bin       (bin_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .bout      (bout),
`ifdef SERIAL_SUB_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic res_t model(input logic [3:0] a, input logic [3:0] b, input logic bin);
    res_t       r;
    logic [4:0] full;
    int         sa;
    int         sbv;
    int         s;
    full   = {1'b0, a} - {1'b0, b} - {4'b0, bin};
    sa     = $signed(a);
    sbv    = $signed(b);
    s      = sa - sbv - int'(bin);
    r.diff = full[3:0];
    r.bout = full[4];
    r.ovf  = (s > 7) || (s < -8);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait (bounded) for in_ready, and record the expected result.
  task automatic accept(input logic [3:0] a, input logic [3:0] b, input logic bin, input bit hold);
    int w = 0;
    a_i      = a;
    b_i      = b;
    bin_i    = bin;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && w < 40) begin
      step();
      w++;
    end
    check("accept_wait", 32'(w < 40), 32'd1);
    sb.push_back(model(a, b, bin));
    step();
    if (!hold) in_valid = 1'b0;
    check("in_ready_busy", 32'(in_ready), 32'd0);
  endtask

  // Wait (bounded) for out_valid, optionally stall it, then compare and consume.
  task automatic collect(input int stall, input bit chk_lat);
    int   lat = 0;
    res_t e;
    out_ready = (stall == 0);
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    if (chk_lat) check("latency", 32'(lat), 32'd4);
    check("out_valid_up", 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < stall; i++) begin
      check("stall_diff", 32'(diff), 32'(e.diff));
      check("stall_bout", 32'(bout), 32'(e.bout));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      step();
    end
    check("diff", 32'(diff), 32'(e.diff));
    check("bout", 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", 32'(ovf), 32'(e.ovf));
`endif
    out_ready = 1'b1;
    step();
    check("after_hs_out_valid", 32'(out_valid), 32'd0);
    check("after_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    a_i       = '0;
    b_i       = '0;
    bin_i     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    rst_n = 1'b1;
    step();

    accept(4'b0101, 4'b0011, 1'b0, 1'b0);
    collect(0, 1'b1);
    accept(4'b0011, 4'b0101, 1'b0, 1'b0);
    collect(0, 1'b1);
    accept(4'b0000, 4'b0000, 1'b1, 1'b0);
    collect(0, 1'b1);

    // Back-pressure for 10 cycles.
    accept(4'b0110, 4'b0010, 1'b0, 1'b0);
    collect(10, 1'b1);

    // in_valid stays high with new operands while busy; only taken after IDLE.
    accept(4'b1000, 4'b0011, 1'b0, 1'b1);
    a_i = 4'b1111;
    b_i = 4'b0001;
    collect(3, 1'b1);
    accept(4'b1111, 4'b0001, 1'b0, 1'b0);
    collect(0, 1'b1);

    // Reset mid-operation discards the in-flight result.
    accept(4'b0101, 4'b0011, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_bout", 32'(bout), 32'd0);
    void'(sb.pop_back());
    step();
    rst_n = 1'b1;
    step();
    accept(4'b1001, 4'b0100, 1'b0, 1'b0);
    collect(0, 1'b1);

    // Signed overflow cases (ovf only checked when the port exists).
    accept(4'b0111, 4'b1000, 1'b0, 1'b0);
    collect(0, 1'b1);
    accept(4'b0101, 4'b0011, 1'b0, 1'b0);
    collect(0, 1'b1);
    accept(4'b1111, 4'b1111, 1'b1, 1'b0);
    collect(2, 1'b1);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
